pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline stage register replacing the fixed-field stage registers between pipeline stages (e.g. execute→memory). It carries an opaque data payload and a separately handled control field, and adds a valid/ready handshake with an optional two-entry skid buffer so that a stalled downstream stage does not combinationally stall upstream. It also provides flush-to-bubble semantics and saturating stall/bubble performance counters.

---
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register: opaque payload plus a control field that is zeroed on bubbles,
// valid/ready handshake with optional two-entry skid buffer, flush, and saturating perf counters.
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic                  take_in;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = main_data_q;
  assign out_ctrl   = main_ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign take_in    = in_valid && in_ready && !flush;

  // With the skid buffer, in_ready comes straight from a flop so out_ready never reaches it.
  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = in_ready_q;
    end else begin : g_flow
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (take_in) begin
            state_d     = ST_FULL;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_FULL: begin
          if (out_ready && take_in) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (out_ready) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end else if (take_in && (SKID_EN != 0)) begin
            state_d     = ST_SKID;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_d     = ST_FULL;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
    in_ready_d = (state_d != ST_SKID);
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (!out_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid-buffer instance (4-bit counters) and a flow-through instance
// run side by side against a queue-level reference model.
module tb_pipe_stage_skid;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, out_ready;
  logic        in_valid [2];
  logic [31:0] in_data  [2];
  logic [7:0]  in_ctrl  [2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic [31:0] out_data [2];
  logic [7:0]  out_ctrl [2];
  logic [3:0]  stall_s, bubble_s;
  logic [15:0] stall_f, bubble_f;

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .SKID_EN(1), .CNT_WIDTH(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
    .stall_cnt(stall_s), .bubble_cnt(bubble_s)
  );

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .SKID_EN(0), .CNT_WIDTH(16)) u_flow (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
    .stall_cnt(stall_f), .bubble_cnt(bubble_f)
  );

  // Reference model: each stage is a FIFO of {ctrl,data} entries with capacity 2 (skid) or 1 (flow).
  logic [39:0] mq[2][2];
  int          mcnt[2]   = '{0, 0};
  int          mstall[2] = '{0, 0};
  int          mbub[2]   = '{0, 0};
  int          cmax[2]   = '{15, 65535};
  string       nm[2]     = '{"skid", "flow"};

  bit          vld_en, rand_mode, ctrl_force_en;
  logic [7:0]  ctrl_force;
  int          rem[2];
  logic [31:0] cur_data[2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_rdy(input int m);
    if (m == 0) return mcnt[0] < 2;
    return (mcnt[1] == 0) || out_ready;
  endfunction

  function automatic int get_stall(input int m);
    return (m == 0) ? int'(stall_s) : int'(stall_f);
  endfunction

  function automatic int get_bubble(input int m);
    return (m == 0) ? int'(bubble_s) : int'(bubble_f);
  endfunction

  task automatic step(input bit do_chk);
    logic acc;
    for (int m = 0; m < 2; m++) begin
      in_valid[m] = vld_en && (rem[m] != 0);
      in_data[m]  = cur_data[m];
      in_ctrl[m]  = ctrl_force_en ? ctrl_force : (cur_data[m][7:0] ^ 8'hC3);
    end
    #1;
    if (do_chk) begin
      for (int m = 0; m < 2; m++) begin
        chk({nm[m], "/in_ready"}, 64'(in_ready[m]), 64'(exp_rdy(m)));
        chk({nm[m], "/out_valid"}, 64'(out_valid[m]), 64'(mcnt[m] != 0));
        chk({nm[m], "/out_ctrl"}, 64'(out_ctrl[m]), (mcnt[m] != 0) ? 64'(mq[m][0][39:32]) : 64'd0);
        if (mcnt[m] != 0) chk({nm[m], "/out_data"}, 64'(out_data[m]), 64'(mq[m][0][31:0]));
        chk({nm[m], "/stall_cnt"}, 64'(get_stall(m)), 64'(mstall[m]));
        chk({nm[m], "/bubble_cnt"}, 64'(get_bubble(m)), 64'(mbub[m]));
      end
    end
    for (int m = 0; m < 2; m++) begin
      acc = rst_n && !flush && in_valid[m] && exp_rdy(m);
      if (!rst_n) begin
        mcnt[m] = 0; mstall[m] = 0; mbub[m] = 0;
      end else begin
        if (mcnt[m] != 0 && !out_ready && mstall[m] < cmax[m]) mstall[m]++;
        if (mcnt[m] == 0 && mbub[m] < cmax[m]) mbub[m]++;
        if (flush) begin
          mcnt[m] = 0;
        end else begin
          if (mcnt[m] != 0 && out_ready) begin
            $display("xfer %s data=%08h ctrl=%02h", nm[m], mq[m][0][31:0], mq[m][0][39:32]);
            mq[m][0] = mq[m][1];
            mcnt[m]--;
          end
          if (acc) begin
            mq[m][mcnt[m]] = {in_ctrl[m], in_data[m]};
            mcnt[m]++;
          end
        end
      end
      if (acc) begin
        rem[m]--;
        cur_data[m] = rand_mode ? $urandom : cur_data[m] + 32'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    vld_en = 1'b1; rand_mode = 1'b0; ctrl_force_en = 1'b0; ctrl_force = 8'h00;
    rem = '{100, 100}; cur_data = '{32'hDEAD, 32'hBEEF};
    // reset with inputs active; nothing may be captured
    step(1'b0);
    step(1'b1);
    chk("skid/rst_data", 64'(out_data[0]), 64'd0);
    chk("flow/rst_data", 64'(out_data[1]), 64'd0);
    rst_n = 1'b1;

    // stream 1..8 at full throughput
    rem = '{8, 8}; cur_data = '{32'h1, 32'h1};
    repeat (10) step(1'b1);
    chk("skid/stream_stall", 64'(stall_s), 64'd0);
    chk("flow/stream_stall", 64'(stall_f), 64'd0);

    // A,B,C with three stalled cycles once A is visible
    rem = '{3, 3}; cur_data = '{32'hA, 32'hA};
    step(1'b1);
    out_ready = 1'b0;
    repeat (3) step(1'b1);
    out_ready = 1'b1;
    repeat (4) step(1'b1);
    chk("skid/abc_stall", 64'(stall_s), 64'd3);
    chk("flow/abc_stall", 64'(stall_f), 64'd3);

    // flush a FULL stage holding ctrl=FF while a new input is offered
    rem = '{2, 2}; cur_data = '{32'h55, 32'h55};
    ctrl_force_en = 1'b1; ctrl_force = 8'hFF; out_ready = 1'b0;
    step(1'b1);
    flush = 1'b1;
    step(1'b1);
    flush = 1'b0; vld_en = 1'b0; ctrl_force_en = 1'b0;
    step(1'b1);
    chk("skid/flush_ctrl", 64'(out_ctrl[0]), 64'd0);
    chk("flow/flush_valid", 64'(out_valid[1]), 64'd0);
    chk("flow/flush_stall_kept", 64'(stall_f), 64'd4);

    // fresh reset, idle, then stall long enough to saturate the 4-bit counter
    rst_n = 1'b0;
    step(1'b1);
    rst_n = 1'b1;
    repeat (5) step(1'b1);
    chk("skid/idle_bubble", 64'(bubble_s), 64'd5);
    chk("flow/idle_bubble", 64'(bubble_f), 64'd5);
    vld_en = 1'b1; rem = '{1, 1}; cur_data = '{32'h1234, 32'h1234};
    repeat (21) step(1'b1);
    chk("skid/stall_sat", 64'(stall_s), 64'hF);
    chk("flow/stall_20", 64'(stall_f), 64'd20);
    out_ready = 1'b1;
    repeat (2) step(1'b1);

    // drive the skid instance into SKID, then reset
    rem = '{2, 2}; cur_data = '{32'h77, 32'h77}; out_ready = 1'b0;
    repeat (2) step(1'b1);
    chk("skid/skid_in_ready", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b0;
    step(1'b1);
    rst_n = 1'b1; vld_en = 1'b0;
    chk("skid/rst_skid_data", 64'(out_data[0]), 64'd0);
    chk("skid/rst_skid_in_ready", 64'(in_ready[0]), 64'd1);
    chk("skid/rst_skid_stall", 64'(stall_s), 64'd0);
    step(1'b1);

    // randomized traffic
    rand_mode = 1'b1; rem = '{100000, 100000};
    cur_data = '{$urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      vld_en    = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      step(1'b1);
    end
    flush = 1'b0; vld_en = 1'b0; out_ready = 1'b1;
    repeat (3) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
